// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the CPU control unit and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src_a, src_b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, src_a, src_b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
// Divider is present only when MULTDIV_DIV_EN is defined; otherwise DIV requests complete as no-ops.
module mult_div_unit #(parameter int WIDTH = 32) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // MULT  | one Booth step per cycle, WIDTH steps
  // DIV   | one restoring quotient bit per cycle, WIDTH steps
  // FIX   | apply result signs, write HI/LO
  // DONE  | done pulse, results held, start accepted
  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef MULTDIV_DIV_EN
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
`endif

  state_t stateReg, stateNext;

  logic [2*WIDTH:0] acc, accNext;
  logic [WIDTH:0]   accUpper, boothSum;
  logic [WIDTH-1:0] multiplicand;
  logic [CW-1:0]    iterCnt;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             busyReg, doneReg, divZeroReg;
  logic             accept, lastIter, busyNext;

  assign accept   = bus.start && (stateReg == IDLE || stateReg == DONE);
  assign lastIter = (iterCnt == LAST_ITER);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE, DONE: begin
        if (!bus.start)  stateNext = IDLE;
        else if (!bus.op) stateNext = MULT;
`ifdef MULTDIV_DIV_EN
        else if (bus.src_b != '0) stateNext = DIV;
`endif
        else stateNext = DONE;
      end
      MULT: if (lastIter) stateNext = DONE;
`ifdef MULTDIV_DIV_EN
      DIV:  if (lastIter) stateNext = FIX;
      FIX:  stateNext = DONE;
`endif
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE) && (stateNext != DONE);
  end

  // Upper half is widened by one bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    accUpper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   boothSum = accUpper + {multiplicand[WIDTH-1], multiplicand};
      2'b10:   boothSum = accUpper - {multiplicand[WIDTH-1], multiplicand};
      default: boothSum = accUpper;
    endcase
    accNext = {boothSum, acc[WIDTH:1]};
  end

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] divisor, quo, rem, remDiff, absA, absB;
  logic [WIDTH:0]   remShift;
  logic             remGe, signDividend, signQuo;

  always_comb begin
    absA     = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
    absB     = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
    remShift = {rem, quo[WIDTH-1]};
    remGe    = (remShift >= {1'b0, divisor});
    remDiff  = remShift[WIDTH-1:0] - divisor;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      multiplicand <= '0;
      iterCnt      <= '0;
      hiReg        <= '0;
      loReg        <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      divZeroReg   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      divisor      <= '0;
      quo          <= '0;
      rem          <= '0;
      signDividend <= 1'b0;
      signQuo      <= 1'b0;
`endif
    end else begin
      busyReg <= busyNext;
      doneReg <= (stateNext == DONE);
      if (accept) begin
        divZeroReg <= 1'b0;
        iterCnt    <= '0;
        if (!bus.op) begin
          acc          <= {{WIDTH{1'b0}}, bus.src_a, 1'b0};
          multiplicand <= bus.src_b;
        end
`ifdef MULTDIV_DIV_EN
        else if (bus.src_b == '0) begin
          divZeroReg <= 1'b1;
        end else begin
          rem          <= '0;
          quo          <= absA;
          divisor      <= absB;
          signDividend <= bus.src_a[WIDTH-1];
          signQuo      <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
        end
`endif
      end else begin
        case (stateReg)
          MULT: begin
            acc     <= accNext;
            iterCnt <= iterCnt + CW'(1);
            if (lastIter) begin
              hiReg <= accNext[2*WIDTH:WIDTH+1];
              loReg <= accNext[WIDTH:1];
            end
          end
`ifdef MULTDIV_DIV_EN
          DIV: begin
            iterCnt <= iterCnt + CW'(1);
            quo     <= {quo[WIDTH-2:0], remGe};
            rem     <= remGe ? remDiff : remShift[WIDTH-1:0];
          end
          FIX: begin
            loReg <= signQuo      ? -quo : quo;
            hiReg <= signDividend ? -rem : rem;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: transaction-level latency/arithmetic model checked every cycle,
// plus hand-computed literal results. Follows MULTDIV_DIV_EN to pick divider expectations.
module tb_mult_div_unit;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  bit   checkEn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: results from plain signed arithmetic, timing as a remaining-cycles count.
  int          remain;
  logic [31:0] pendHi, pendLo, expHi, expLo;
  logic        expBusy, expDone, expDz;
  longint      sa, sb, prod, quot, remd;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      remain = 0; expBusy = 0; expDone = 0; expDz = 0; expHi = 0; expLo = 0;
    end else begin
      expDone = 0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          expBusy = 0; expDone = 1; expHi = pendHi; expLo = pendLo;
        end
      end else if (bus.start) begin
        expDz = 0;
        sa = longint'($signed(bus.src_a));
        sb = longint'($signed(bus.src_b));
        if (!bus.op) begin
          prod   = sa * sb;
          pendHi = prod[63:32];
          pendLo = prod[31:0];
          remain = 32; expBusy = 1;
        end else if (!DIV_EN) begin
          expDone = 1;
        end else if (sb == 0) begin
          expDone = 1; expDz = 1;
        end else begin
          quot   = sa / sb;
          remd   = sa % sb;
          pendLo = quot[31:0];
          pendHi = remd[31:0];
          remain = 33; expBusy = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn && !reset) begin
      chk("cyc_busy", {31'b0, bus.busy}, {31'b0, expBusy});
      chk("cyc_done", {31'b0, bus.done}, {31'b0, expDone});
      chk("cyc_div_zero", {31'b0, bus.div_zero}, {31'b0, expDz});
      chk("cyc_hi", bus.hi, expHi);
      chk("cyc_lo", bus.lo, expLo);
    end
  end

  task automatic launch(input logic opIn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1; bus.op = opIn; bus.src_a = a; bus.src_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle in which done was seen (60 if never).
  task automatic waitDone(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic checkResult(input string name, input int cyc, input int expLat,
                             input logic [31:0] hiE, input logic [31:0] loE, input logic dzE);
    chk({name, "_latency"}, cyc, expLat);
    chk({name, "_hi"}, bus.hi, hiE);
    chk({name, "_lo"}, bus.lo, loE);
    chk({name, "_div_zero"}, {31'b0, bus.div_zero}, {31'b0, dzE});
  endtask

  task automatic runOp(input string name, input logic opIn, input logic [31:0] a, input logic [31:0] b,
                       input int expLat, input logic [31:0] hiE, input logic [31:0] loE, input logic dzE);
    int cyc;
    launch(opIn, a, b);
    waitDone(cyc);
    checkResult(name, cyc, expLat, hiE, loE, dzE);
  endtask

  initial begin
    int cyc, doneCount, doneCycle;
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkEn = 1'b1;
    #1;
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_div_zero", {31'b0, bus.div_zero}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    repeat (2) @(posedge clock);

    runOp("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("mult_min_min", 1'b0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0);
    runOp("mult_max_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    repeat (3) @(posedge clock);

    runOp("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, DIV_EN ? 34 : 1,
          DIV_EN ? 32'hFFFFFFFF : 32'h3FFFFFFF, DIV_EN ? 32'hFFFFFFFD : 32'h00000001, 1'b0);
    runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, DIV_EN ? 34 : 1,
          DIV_EN ? 32'h00000001 : 32'h3FFFFFFF, DIV_EN ? 32'hFFFFFFFD : 32'h00000001, 1'b0);
    runOp("div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 34 : 1,
          DIV_EN ? 32'h00000000 : 32'h3FFFFFFF, DIV_EN ? 32'h80000000 : 32'h00000001, 1'b0);

    // 0x66 * 0x2AAAAAAB = 0x11_00000022 leaves hi=0x11, lo=0x22 for the divide-by-zero case.
    runOp("mult_prior", 1'b0, 32'h00000066, 32'h2AAAAAAB, 33, 32'h00000011, 32'h00000022, 1'b0);
    repeat (2) @(posedge clock);
    runOp("div_by_zero", 1'b1, 32'd5, 32'd0, 1, 32'h00000011, 32'h00000022, DIV_EN);
    repeat (2) @(posedge clock);

    // Running MULT with ignored start pulses, then a new request accepted in the DONE cycle.
    launch(1'b0, 32'h00001234, 32'hFFFFFFAB);
    chk("div_zero_cleared", {31'b0, bus.div_zero}, 32'd0);
    doneCount = 0; doneCycle = 0;
    for (int c = 1; c <= 33; c++) begin
      if (bus.done === 1'b1) begin
        doneCount++; doneCycle = c;
      end
      if (c == 33) chk("ignore_lo", bus.lo, 32'hFFF9F4BC);
      if (c == 5 || c == 20 || c == 33) begin
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = (c == 33) ? 1'b0 : 1'b1;
        bus.src_a = (c == 33) ? 32'hFFFFFFFF : 32'd5;
        bus.src_b = (c == 33) ? 32'hFFFFFFFF : 32'd0;
        @(posedge clock); #1;
        bus.start = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
    end
    chk("ignore_done_count", doneCount, 1);
    chk("ignore_done_cycle", doneCycle, 33);
    waitDone(cyc);
    checkResult("b2b_m1_m1", cyc, 33, 32'h00000000, 32'h00000001, 1'b0);

    // Asynchronous reset in the middle of cycle 10 of a divide.
    launch(1'b1, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clock); #1;
    end
    chk("busy_before_reset", {31'b0, bus.busy}, {31'b0, DIV_EN});
    #3 reset = 1'b1;
    #1;
    chk("async_busy", {31'b0, bus.busy}, 32'd0);
    chk("async_done", {31'b0, bus.done}, 32'd0);
    chk("async_hi", bus.hi, 32'd0);
    chk("async_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    runOp("mult_3_4", 1'b0, 32'd3, 32'd4, 33, 32'd0, 32'd12, 1'b0);
    repeat (3) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
